// File: rtl/phy_tx_pkg.sv
// Shared constants and types for the PHY transmit serializer.
package phy_tx_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned SYNC_CNT_W = 4;

  localparam logic [BYTE_W-1:0] COM_SYMBOL = 8'hBC;

  localparam logic [0:0] SYNC   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  // Byte offered to the shift register at the next byte boundary.
  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic              is_data;
  } load_t;

endpackage

// File: rtl/par2serial_tx_if.sv
// Byte-in / bit-out bus of the transmit serializer.
interface par2serial_tx_if;
  import phy_tx_pkg::*;

  logic [BYTE_W-1:0] data_in;
  logic              valid_in;
  logic              ready_out;
  logic              serial_out;
  logic              data_bit_out;
  logic              active_out;

  modport master (
    output data_in, valid_in,
    input  ready_out, serial_out, data_bit_out, active_out
  );

  modport slave (
    input  data_in, valid_in,
    output ready_out, serial_out, data_bit_out, active_out
  );

endinterface

// File: rtl/piso_shift8.sv
// 8-bit load/shift register, MSB first, with a per-byte data flag and bit counter.
module piso_shift8
  import phy_tx_pkg::*;
#(
  parameter logic [BYTE_W-1:0] IDLE_BYTE = COM_SYMBOL
) (
  input  logic             clk,
  input  logic             reset_L,
  input  load_t            load_i,
  output logic [CNT_W-1:0] bit_cnt_o,
  output logic             serial_o,
  output logic             data_bit_o
);

  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              flag_q, flag_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              serial_q, serial_d;
  logic              data_bit_q, data_bit_d;

  // Shift every clock; reload from load_i on the last bit of a byte.
  always_comb begin
    shift_d    = shift_q << 1;
    flag_d     = flag_q;
    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
    serial_d   = shift_q[BYTE_W-1];
    data_bit_d = flag_q;
    if (bit_cnt_q == CNT_W'(BYTE_W - 1)) begin
      shift_d   = load_i.data;
      flag_d    = load_i.is_data;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      shift_q    <= IDLE_BYTE;
      flag_q     <= 1'b0;
      bit_cnt_q  <= '0;
      serial_q   <= 1'b0;
      data_bit_q <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      flag_q     <= flag_d;
      bit_cnt_q  <= bit_cnt_d;
      serial_q   <= serial_d;
      data_bit_q <= data_bit_d;
    end
  end

  assign bit_cnt_o  = bit_cnt_q;
  assign serial_o   = serial_q;
  assign data_bit_o = data_bit_q;

endmodule

// File: rtl/par2serial_tx.sv
// Transmit serializer: COM training burst after reset, then data bytes with COM idle fill.
module par2serial_tx
  import phy_tx_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COM_SYMBOL = phy_tx_pkg::COM_SYMBOL,
  parameter int unsigned       SYNC_COUNT = 4
) (
  input  logic            clk,
  input  logic            reset_L,
  par2serial_tx_if.slave  bus
);

  logic [0:0]            state_q, state_d;
  logic [SYNC_CNT_W-1:0] sync_cnt_q, sync_cnt_d;
  logic                  ready_q, ready_d;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  boundary;
  load_t                 load;

  assign boundary = (bit_cnt == CNT_W'(BYTE_W - 1));

  // FSM, sync counter and next-slot ready decode.
  always_comb begin
    state_d      = state_q;
    sync_cnt_d   = sync_cnt_q;
    load.is_data = (state_q == ACTIVE) && bus.valid_in;
    load.data    = load.is_data ? bus.data_in : COM_SYMBOL;
    if (boundary && (state_q == SYNC)) begin
      sync_cnt_d = sync_cnt_q + SYNC_CNT_W'(1);
      if (sync_cnt_q == SYNC_CNT_W'(SYNC_COUNT - 1)) begin
        state_d = ACTIVE;
      end
    end
    // ready_q mirrors (state == ACTIVE && bit_cnt == 7) one edge ahead.
    ready_d = (state_d == ACTIVE) && (bit_cnt == CNT_W'(BYTE_W - 2));
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= SYNC;
      sync_cnt_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      ready_q    <= ready_d;
    end
  end

  piso_shift8 #(
    .IDLE_BYTE (COM_SYMBOL)
  ) u_piso (
    .clk        (clk),
    .reset_L    (reset_L),
    .load_i     (load),
    .bit_cnt_o  (bit_cnt),
    .serial_o   (bus.serial_out),
    .data_bit_o (bus.data_bit_out)
  );

  assign bus.ready_out  = ready_q;
  assign bus.active_out = (state_q == ACTIVE);

endmodule

// File: tb/tb_par2serial_tx.sv
// Directed bench for par2serial_tx: sync burst, data, idle fill, early valid, mid-byte reset.
module tb_par2serial_tx;

  localparam logic [7:0] COM = 8'hBC;

  logic clk;
  logic reset_L;
  int   checks;
  int   errors;

  par2serial_tx_if bus ();

  par2serial_tx #(
    .COM_SYMBOL (8'hBC),
    .SYNC_COUNT (4)
  ) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One byte period: check 8 output bits, ready and active; apply next inputs at tick set_at.
  task automatic byte_cycle(input string tag, input logic [7:0] exp_byte, input logic exp_flag,
                            input logic exp_rdy, input logic exp_act,
                            input logic nv, input logic [7:0] nd, input int set_at);
    for (int i = 0; i < 8; i++) begin
      if (i == set_at) begin
        bus.valid_in = nv;
        bus.data_in  = nd;
      end
      tick();
      chk({tag, "_ser"}, 8'(bus.serial_out), 8'(exp_byte[7-i]));
      chk({tag, "_dbit"}, 8'(bus.data_bit_out), 8'(exp_flag));
      chk({tag, "_rdy"}, 8'(bus.ready_out), (i == 6) ? 8'(exp_rdy) : 8'h00);
    end
    chk({tag, "_act"}, 8'(bus.active_out), 8'(exp_act));
  endtask

  task automatic sync_burst(input string tag);
    for (int c = 0; c < 5; c++) begin
      byte_cycle(tag, COM, 1'b0, (c == 4), (c >= 3), 1'b0, 8'h00, 0);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset_L      = 1'b0;
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    repeat (2) tick();
    chk("rst_ser", 8'(bus.serial_out), 8'h00);
    chk("rst_dbit", 8'(bus.data_bit_out), 8'h00);
    chk("rst_act", 8'(bus.active_out), 8'h00);
    chk("rst_rdy", 8'(bus.ready_out), 8'h00);
    @(negedge clk);
    reset_L = 1'b1;

    // Edges 1..32: four SYNC COMs; active rises after edge 32.
    for (int c = 0; c < 4; c++) begin
      byte_cycle("sync", COM, 1'b0, 1'b0, (c == 3), (c == 3), 8'hA5, (c == 3) ? 8 : 0);
    end
    // valid applied right after edge 32: fifth COM, then A5 loaded at edge 40.
    byte_cycle("sync5", COM, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 0);
    byte_cycle("a5", 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 0);
    byte_cycle("s01", 8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 0);
    byte_cycle("sff", 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 8'h80, 0);
    byte_cycle("s80", 8'h80, 1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 0);
    byte_cycle("s3c", 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 0);
    byte_cycle("idle", COM, 1'b0, 1'b1, 1'b1, 1'b1, 8'hC3, 0);
    byte_cycle("sc3", 8'hC3, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 0);
    // 55 raised at bit_cnt==3 of an idle byte; must go out exactly once.
    byte_cycle("early", COM, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 3);
    byte_cycle("s55", 8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 0);
    byte_cycle("nodup", COM, 1'b0, 1'b1, 1'b1, 1'b1, 8'hF0, 0);

    // F0 in flight; reset at bit_cnt==4.
    bus.valid_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("f0_ser", 8'(bus.serial_out), 8'h01);
      chk("f0_dbit", 8'(bus.data_bit_out), 8'h01);
    end
    #2 reset_L = 1'b0;
    #1;
    chk("mrst_ser", 8'(bus.serial_out), 8'h00);
    chk("mrst_dbit", 8'(bus.data_bit_out), 8'h00);
    chk("mrst_act", 8'(bus.active_out), 8'h00);
    chk("mrst_rdy", 8'(bus.ready_out), 8'h00);
    tick();
    chk("mrst_hold", 8'(bus.serial_out), 8'h00);
    @(negedge clk);
    reset_L = 1'b1;
    sync_burst("resync");
    byte_cycle("post", COM, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
